// File: rtl/wb_trace_buffer_pkg.sv
// trace_pkg: shared types and constants for the WB trace buffer.
//   trace_entry_t  - one captured write-back at the default widths
//                    (TS_W=16, PC_W=14, XLEN=32), field order {ts,pc,rd,data}
//   WRAP_*         - encodings for the WRAP_MODE parameter
//   entry_w()      - packed entry width for arbitrary field widths
package trace_pkg;

  localparam int WRAP_DROP      = 0;  // full buffer discards the new entry
  localparam int WRAP_OVERWRITE = 1;  // full buffer discards the oldest entry

  localparam int DEF_XLEN = 32;
  localparam int DEF_PC_W = 14;
  localparam int DEF_TS_W = 16;

  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    logic [DEF_PC_W-1:0] pc;
    logic [4:0]          rd;
    logic [DEF_XLEN-1:0] data;
  } trace_entry_t;

  function automatic int entry_w(int ts_w, int pc_w, int xlen);
    return ts_w + pc_w + 5 + xlen;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: write-back capture inputs and the trace read port.
//   wb_valid/wb_we/wb_rd/wb_data/wb_pc : WB stage observation (master drives)
//   out_valid/out_entry                : oldest entry, FWFT (slave drives)
//   out_ready                          : consumer pops the head (master drives)
interface wb_trace_buffer_if
  import trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 14,
  parameter int TS_W = 16
);

  logic                                  wb_valid;
  logic                                  wb_we;
  logic [4:0]                            wb_rd;
  logic [XLEN-1:0]                       wb_data;
  logic [PC_W-1:0]                       wb_pc;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [entry_w(TS_W, PC_W, XLEN)-1:0]  out_entry;

  modport slave (
    input  wb_valid, wb_we, wb_rd, wb_data, wb_pc, out_ready,
    output out_valid, out_entry
  );

  modport master (
    output wb_valid, wb_we, wb_rd, wb_data, wb_pc, out_ready,
    input  out_valid, out_entry
  );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// trace_fifo: generic synchronous FIFO, first-word-fall-through.
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   push      - write wdata (ignored during rst)
//   pop       - remove head; ignored while empty
//   rdata     - head entry, valid while count != 0
//   count     - occupancy 0..DEPTH
//   dropped   - a push hit a full FIFO with no simultaneous pop; the new
//               entry (OVERWRITE=0) or the oldest one (OVERWRITE=1) is lost
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// Storage is not reset.
module trace_fifo #(
  parameter int  W         = 8,
  parameter int  DEPTH     = 16,
  parameter bit  OVERWRITE = 1'b0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          dropped
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          empty, full;
  logic          do_pop, do_push, overwrite;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  assign do_pop    = pop & ~empty;
  // Pushing into a full FIFO only succeeds when a pop frees the head slot
  // in the same cycle, or when the oldest entry may be sacrificed.
  assign do_push   = push & (~full | do_pop | OVERWRITE);
  // Full means wptr == rptr, so writing at wptr replaces the oldest entry;
  // advancing both pointers keeps the order and the count.
  assign overwrite = push & full & ~do_pop & OVERWRITE;
  assign dropped   = push & full & ~do_pop;

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)             wptr <= wptr + AW'(1);
      if (do_pop || overwrite) rptr <= rptr + AW'(1);
      if (do_push && !do_pop && !overwrite) count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)          count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: records register write-backs {ts,pc,rd,data} into a
// small FIFO for a debug reader, with overflow accounting and a
// no-write-back watchdog.
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   cap_en       - capture enable
//   bus          - WB observation inputs and FWFT read port (slave side)
//   count        - buffer occupancy
//   ovf_cnt      - saturating count of entries lost to a full buffer
//   timeout      - sticky: no register write for TIMEOUT_CYC cycles
//   clr_timeout  - clears timeout (wins over a same-cycle set)
// Writes to x0 are not recorded but still feed the watchdog.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_W        = 14,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int WRAP_MODE   = WRAP_DROP,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  wb_trace_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              ovf_cnt,
  output logic                     timeout,
  input  logic                     clr_timeout
);

  localparam int EW   = entry_w(TS_W, PC_W, XLEN);
  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  // Same layout as trace_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic [TS_W-1:0] ts;
  logic            reg_write, capture, dropped, wd_hit;
  logic [WD_W-1:0] wd;
  entry_t          wr_entry;

  // Free-running timestamp, 0 in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  assign reg_write = bus.wb_valid & bus.wb_we;
  assign capture   = cap_en & reg_write & (bus.wb_rd != 5'd0) & ~rst;

  assign wr_entry = '{ts: ts, pc: bus.wb_pc, rd: bus.wb_rd, data: bus.wb_data};

  trace_fifo #(
    .W         (EW),
    .DEPTH     (DEPTH),
    .OVERWRITE (WRAP_MODE == WRAP_OVERWRITE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture),
    .pop     (bus.out_ready),
    .wdata   (wr_entry),
    .rdata   (bus.out_entry),
    .count   (count),
    .dropped (dropped)
  );

  assign bus.out_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (rst)                             ovf_cnt <= '0;
    else if (dropped && ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 16'd1;
  end

  // Watchdog saturates at the limit so the set condition stays asserted
  // until a write or a clear restarts it. With TIMEOUT_CYC=0 the limit is
  // never treated as reached.
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      if (reg_write || (clr_timeout && wd_hit)) wd <= '0;
      else if (wd != WD_LIMIT)                  wd <= wd + WD_W'(1);

      if (clr_timeout) timeout <= 1'b0;
      else if (wd_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;
  import trace_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cap_en, clr_timeout;
  logic        wb_valid, wb_we, out_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [13:0] wb_pc;

  logic [2:0]  count_a, count_b;
  logic [15:0] ovf_a, ovf_b;
  logic        to_a, to_b;

  wb_trace_buffer_if #(.XLEN(32), .PC_W(14), .TS_W(16)) bus_a ();
  wb_trace_buffer_if #(.XLEN(32), .PC_W(14), .TS_W(16)) bus_b ();

  assign bus_a.wb_valid = wb_valid;  assign bus_b.wb_valid = wb_valid;
  assign bus_a.wb_we    = wb_we;     assign bus_b.wb_we    = wb_we;
  assign bus_a.wb_rd    = wb_rd;     assign bus_b.wb_rd    = wb_rd;
  assign bus_a.wb_data  = wb_data;   assign bus_b.wb_data  = wb_data;
  assign bus_a.wb_pc    = wb_pc;     assign bus_b.wb_pc    = wb_pc;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

  // a: drop-new, watchdog 10; b: overwrite-oldest, watchdog disabled
  wb_trace_buffer #(.XLEN(32), .PC_W(14), .DEPTH(4), .TS_W(16),
                    .WRAP_MODE(WRAP_DROP), .TIMEOUT_CYC(10)) dut_a (
    .clk(clk), .rst(rst), .cap_en(cap_en), .bus(bus_a.slave),
    .count(count_a), .ovf_cnt(ovf_a), .timeout(to_a), .clr_timeout(clr_timeout));

  wb_trace_buffer #(.XLEN(32), .PC_W(14), .DEPTH(4), .TS_W(16),
                    .WRAP_MODE(WRAP_OVERWRITE), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .cap_en(cap_en), .bus(bus_b.slave),
    .count(count_b), .ovf_cnt(ovf_b), .timeout(to_b), .clr_timeout(clr_timeout));

  int tests = 0, fails = 0;
  int cyc = 0;
  int ovf_a_m = 0, ovf_b_m = 0;
  trace_entry_t sb_a[$], sb_b[$];

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    cap_en = 1'b0; wb_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0;
    wb_data = 32'd0; wb_pc = 14'd0; out_ready = 1'b0; clr_timeout = 1'b0;
  endtask

  function automatic trace_entry_t mk(input logic [4:0] rd, input logic [31:0] d,
                                      input logic [13:0] pc);
    trace_entry_t e;
    e.ts = 16'(cyc); e.pc = pc; e.rd = rd; e.data = d;
    return e;
  endfunction

  // One capture with out_ready low; the model applies each buffer's full policy.
  task automatic cap(input logic [4:0] rd, input logic [31:0] d);
    trace_entry_t e, x;
    cap_en = 1'b1; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = rd; wb_data = d;
    wb_pc = d[13:0] ^ 14'h1555;
    e = mk(rd, d, wb_pc);
    if (sb_a.size() < 4) sb_a.push_back(e); else ovf_a_m++;
    if (sb_b.size() == 4) begin x = sb_b.pop_front(); ovf_b_m++; end
    sb_b.push_back(e);
    tick();
    wb_valid = 1'b0; wb_we = 1'b0;
  endtask

  task automatic drain();
    trace_entry_t ex, got;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!bus_a.out_valid && !bus_b.out_valid && sb_a.size() == 0 && sb_b.size() == 0) break;
      if (bus_a.out_valid) begin
        tests++; got = bus_a.out_entry;
        if (sb_a.size() == 0) begin
          fails++; $display("FAIL drain_a_extra: got %h, required no entry", got);
        end else begin
          ex = sb_a.pop_front();
          if (got !== ex) begin fails++; $display("FAIL drain_a_entry: got %h required %h", got, ex); end
        end
      end
      if (bus_b.out_valid) begin
        tests++; got = bus_b.out_entry;
        if (sb_b.size() == 0) begin
          fails++; $display("FAIL drain_b_extra: got %h, required no entry", got);
        end else begin
          ex = sb_b.pop_front();
          if (got !== ex) begin fails++; $display("FAIL drain_b_entry: got %h required %h", got, ex); end
        end
      end
      tick();
    end
    out_ready = 1'b0;
    tests++;
    if (sb_a.size() != 0 || sb_b.size() != 0 || count_a !== 3'd0 || count_b !== 3'd0) begin
      fails++;
      $display("FAIL drain_empty: left a=%0d b=%0d counts a=%0d b=%0d, required all 0",
               sb_a.size(), sb_b.size(), count_a, count_b);
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; cyc = 0;
    sb_a.delete(); sb_b.delete(); ovf_a_m = 0; ovf_b_m = 0;
    tests++;
    if (count_a !== 3'd0 || bus_a.out_valid !== 1'b0 || ovf_a !== 16'd0 || to_a !== 1'b0) begin
      fails++; $display("FAIL reset_a: count=%0d valid=%b ovf=%0d to=%b, required 0", count_a, bus_a.out_valid, ovf_a, to_a);
    end
    tests++;
    if (count_b !== 3'd0 || bus_b.out_valid !== 1'b0 || ovf_b !== 16'd0 || to_b !== 1'b0) begin
      fails++; $display("FAIL reset_b: count=%0d valid=%b ovf=%0d to=%b, required 0", count_b, bus_b.out_valid, ovf_b, to_b);
    end
  endtask

  task automatic test_first_entry();
    trace_entry_t e, ga, gb;
    tick(); tick(); tick();                       // cycle 3
    cap_en = 1'b1; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5;
    wb_data = 32'h1234; wb_pc = 14'h0ABC;
    e.ts = 16'd3; e.pc = 14'h0ABC; e.rd = 5'd5; e.data = 32'h1234;
    sb_a.push_back(e); sb_b.push_back(e);
    tests++;
    if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL first_valid_c3: got %b required 0", bus_a.out_valid); end
    tick();                                       // cycle 4: x0 write
    wb_rd = 5'd0; wb_data = 32'h55;
    ga = bus_a.out_entry; gb = bus_b.out_entry;
    tests++;
    if (bus_a.out_valid !== 1'b1 || bus_b.out_valid !== 1'b1) begin
      fails++; $display("FAIL first_valid_c4: got a=%b b=%b required 1", bus_a.out_valid, bus_b.out_valid);
    end
    tests++;
    if (ga.ts !== 16'd3 || ga.rd !== 5'd5 || ga.data !== 32'h1234 || gb !== ga) begin
      fails++; $display("FAIL first_entry: got ts=%0d rd=%0d data=%h required ts=3 rd=5 data=1234", ga.ts, ga.rd, ga.data);
    end
    tick();
    idle();
    tests++;
    if (count_a !== 3'd1 || count_b !== 3'd1) begin
      fails++; $display("FAIL x0_ignored: count a=%0d b=%0d required 1", count_a, count_b);
    end
    drain();
  endtask

  task automatic test_overflow();
    trace_entry_t ga, gb;
    for (int d = 1; d <= 6; d++) cap(5'd7, 32'(d));
    idle();
    ga = bus_a.out_entry; gb = bus_b.out_entry;
    tests++;
    if (count_a !== 3'd4 || ovf_a !== 16'd2) begin
      fails++; $display("FAIL drop_full: count=%0d ovf=%0d required 4 and 2", count_a, ovf_a);
    end
    tests++;
    if (count_b !== 3'd4 || ovf_b !== 16'd2) begin
      fails++; $display("FAIL wrap_full: count=%0d ovf=%0d required 4 and 2", count_b, ovf_b);
    end
    tests++;
    if (ga.data !== 32'd1 || gb.data !== 32'd3) begin
      fails++; $display("FAIL full_heads: got a=%0d b=%0d required 1 and 3", ga.data, gb.data);
    end
    drain();
  endtask

  task automatic test_full_pop();
    trace_entry_t e, ex, ga, gb;
    for (int d = 10; d <= 13; d++) cap(5'd3, 32'(d));
    cap_en = 1'b1; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd3;
    wb_data = 32'd14; wb_pc = 14'h0014; out_ready = 1'b1;
    e = mk(5'd3, 32'd14, 14'h0014);
    ga = bus_a.out_entry; ex = sb_a.pop_front();
    tests++;
    if (ga !== ex) begin fails++; $display("FAIL full_pop_head_a: got %h required %h", ga, ex); end
    gb = bus_b.out_entry; ex = sb_b.pop_front();
    tests++;
    if (gb !== ex) begin fails++; $display("FAIL full_pop_head_b: got %h required %h", gb, ex); end
    sb_a.push_back(e); sb_b.push_back(e);
    tick();
    idle();
    ga = bus_a.out_entry; gb = bus_b.out_entry;
    tests++;
    if (count_a !== 3'd4 || count_b !== 3'd4 || ovf_a !== 16'(ovf_a_m) || ovf_b !== 16'(ovf_b_m)) begin
      fails++; $display("FAIL full_pop_count: count a=%0d b=%0d ovf a=%0d b=%0d required 4,4,%0d,%0d",
                        count_a, count_b, ovf_a, ovf_b, ovf_a_m, ovf_b_m);
    end
    tests++;
    if (ga.data !== 32'd11 || gb.data !== 32'd11) begin
      fails++; $display("FAIL full_pop_advance: head a=%0d b=%0d required 11", ga.data, gb.data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int d = 20; d <= 22; d++) cap(5'd9, 32'(d));
    rst = 1'b1;
    cap_en = 1'b1; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'd23;
    tick();
    rst = 1'b0; cyc = 0; idle();
    sb_a.delete(); sb_b.delete(); ovf_a_m = 0; ovf_b_m = 0;
    tests++;
    if (count_a !== 3'd0 || bus_a.out_valid !== 1'b0 || ovf_a !== 16'd0) begin
      fails++; $display("FAIL mid_reset_a: count=%0d valid=%b ovf=%0d required 0", count_a, bus_a.out_valid, ovf_a);
    end
    tests++;
    if (count_b !== 3'd0 || bus_b.out_valid !== 1'b0 || ovf_b !== 16'd0) begin
      fails++; $display("FAIL mid_reset_b: count=%0d valid=%b ovf=%0d required 0", count_b, bus_b.out_valid, ovf_b);
    end
  endtask

  task automatic test_timeout();
    while (cyc < 10) tick();
    tests++;
    if (to_a !== 1'b0) begin fails++; $display("FAIL timeout_c10: got %b required 0", to_a); end
    tick();
    tests++;
    if (to_a !== 1'b1) begin fails++; $display("FAIL timeout_c11: got %b required 1", to_a); end
    tick();                                        // cycle 12
    clr_timeout = 1'b1;
    tick();                                        // cycle 13
    clr_timeout = 1'b0;
    tests++;
    if (to_a !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b required 0", to_a); end
    while (cyc < 18) tick();
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd0;  // x0 write restarts watchdog
    tick();
    idle();
    while (cyc < 29) tick();
    tests++;
    if (to_a !== 1'b0) begin fails++; $display("FAIL timeout_restart_c29: got %b required 0", to_a); end
    tick();
    tests++;
    if (to_a !== 1'b1) begin fails++; $display("FAIL timeout_restart_c30: got %b required 1", to_a); end
    tests++;
    if (to_b !== 1'b0) begin fails++; $display("FAIL timeout_disabled: got %b required 0", to_b); end
  endtask

  initial begin
    idle(); rst = 1'b1;
    test_reset();
    test_first_entry();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: run did not complete, required completion");
    $fatal(1);
  end

endmodule
